// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if
//   Instruction handshake from the fetch stage plus the operand/result bus to
//   the ALU, as seen by alu_dispatch.
//   instr_valid/instr_ready/instr : 16-bit instruction handshake
//   alu_a/alu_b/alu_opcode        : operands and opcode issued to the ALU
//   alu_sreg_o                    : SREG handed to the ALU status input
//   alu_out/alu_sreg_i            : ALU result and returned status byte
// Modports:
//   slave  : alu_dispatch side (accepts instructions, drives the ALU inputs)
//   master : fetch stage + ALU side (presents instructions, returns results)
interface alu_dispatch_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_sreg_o;
    logic [7:0]  alu_out;
    logic [7:0]  alu_sreg_i;

    modport slave (
        input  instr_valid, instr, alu_out, alu_sreg_i,
        output instr_ready, alu_a, alu_b, alu_opcode, alu_sreg_o
    );

    modport master (
        output instr_valid, instr, alu_out, alu_sreg_i,
        input  instr_ready, alu_a, alu_b, alu_opcode, alu_sreg_o
    );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch
//   Issue/writeback controller in front of a registered ALU. Holds a 4x8
//   register file and the 8-bit SREG, issues ALU ops, waits out the ALU
//   latency and writes result and returned status back. LDI is executed
//   locally; opcodes 1001-1111 are rejected.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : instruction handshake and ALU bus (alu_dispatch_if.slave)
//   done      : one-cycle pulse, an instruction retired
//   illegal   : one-cycle pulse, an undefined opcode was rejected
//   sreg      : architectural SREG
//   dbg_sel   : register-file read select
//   dbg_data  : R[dbg_sel], combinational
module alu_dispatch #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_dispatch_if.slave bus,
    output logic          done,
    output logic          illegal,
    output logic [7:0]    sreg,
    input  logic [1:0]    dbg_sel,
    output logic [7:0]    dbg_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [3:0] OP_LDI   = 4'b1000;
    localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] rd_q, rd_d;
    logic [7:0] rf_q [4];
    logic [7:0] rf_d [4];
    logic [7:0] sreg_q, sreg_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] alu_sreg_q, alu_sreg_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [7:0] in_imm;
    logic       xfer;

    assign in_op  = bus.instr[15:12];
    assign in_rd  = bus.instr[11:10];
    assign in_rs  = bus.instr[9:8];
    assign in_imm = bus.instr[7:0];

    assign bus.instr_ready = (state_q == IDLE) && !rst;
    assign xfer            = bus.instr_valid && bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rf_d       = rf_q;
        sreg_d     = sreg_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_sreg_d = alu_sreg_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!in_op[3]) begin
                        // opcode bit2 selects the immediate form
                        rd_d       = in_rd;
                        alu_a_d    = rf_q[in_rd];
                        alu_b_d    = in_op[2] ? in_imm : rf_q[in_rs];
                        alu_op_d   = in_op;
                        alu_sreg_d = sreg_q;
                        state_d    = ISSUE;
                    end else if (in_op == OP_LDI) begin
                        rf_d[in_rd] = in_imm;
                        done_d      = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WB: begin
                rf_d[rd_q] = bus.alu_out;
                sreg_d     = bus.alu_sreg_i;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            sreg_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_sreg_q <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rf_q       <= rf_d;
            sreg_q     <= sreg_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_sreg_q <= alu_sreg_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_sreg_o = alu_sreg_q;
    assign done           = done_q;
    assign illegal        = illegal_q;
    assign sreg           = sreg_q;
    assign dbg_data       = rf_q[dbg_sel];
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: two instances (ALU_LATENCY 1 and 3), each fed by a
// small registered ALU model; expected register/SREG values are queued when an
// instruction is presented and compared when the DUT signals done.
module tb_alu_dispatch;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct packed {
        logic [1:0] rd;
        logic [7:0] val;
        logic [7:0] sreg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    alu_dispatch_if bus_a ();
    alu_dispatch_if bus_b ();

    logic       done_a, illegal_a, done_b, illegal_b;
    logic [7:0] sreg_a, sreg_b, dbg_data_a, dbg_data_b;
    logic [1:0] dbg_sel_a, dbg_sel_b;

    alu_dispatch #(.ALU_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .done(done_a), .illegal(illegal_a),
        .sreg(sreg_a), .dbg_sel(dbg_sel_a), .dbg_data(dbg_data_a)
    );

    alu_dispatch #(.ALU_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .done(done_b), .illegal(illegal_b),
        .sreg(sreg_b), .dbg_sel(dbg_sel_b), .dbg_data(dbg_data_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] ref_rf [2][4];
    logic [7:0] ref_sreg [2];

    // ALU model: {result, status}. Logical ops pass status through; ADD/SUB
    // set N (bit7), V (bit6, unsigned carry/borrow out) and Z (bit5) and keep
    // the remaining status bits as supplied.
    function automatic logic [15:0] alu_model(input logic [3:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] s);
        logic [8:0] w;
        logic [7:0] r;
        logic [7:0] ns;
        ns = s;
        w  = '0;
        case (op[1:0])
            2'd0: r = a & b;
            2'd1: r = a | b;
            2'd2: w = {1'b0, a} + {1'b0, b};
            default: w = {1'b0, a} - {1'b0, b};
        endcase
        if (op[1]) begin
            r     = w[7:0];
            ns[7] = r[7];
            ns[6] = w[8];
            ns[5] = (r == 8'h00);
        end
        return {r, ns};
    endfunction

    logic [15:0] pipe_a [LAT_A];
    logic [15:0] pipe_b [LAT_B];

    always @(posedge clk) begin
        pipe_a[0] <= alu_model(bus_a.alu_opcode, bus_a.alu_a, bus_a.alu_b, bus_a.alu_sreg_o);
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= alu_model(bus_b.alu_opcode, bus_b.alu_a, bus_b.alu_b, bus_b.alu_sreg_o);
        for (int j = 1; j < LAT_B; j++) pipe_b[j] <= pipe_b[j-1];
    end

    assign bus_a.alu_out    = pipe_a[LAT_A-1][15:8];
    assign bus_a.alu_sreg_i = pipe_a[LAT_A-1][7:0];
    assign bus_b.alu_out    = pipe_b[LAT_B-1][15:8];
    assign bus_b.alu_sreg_i = pipe_b[LAT_B-1][7:0];

    // Reference architectural state; queues the expected write per instruction.
    task automatic push_exp(input int u, input logic [15:0] ins);
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        logic [15:0] r;
        exp_t        e;
        op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
        if (!op[3]) begin
            r = alu_model(op, ref_rf[u][rd], op[2] ? imm : ref_rf[u][rs], ref_sreg[u]);
            ref_rf[u][rd] = r[15:8];
            ref_sreg[u]   = r[7:0];
        end else if (op == 4'h8) begin
            ref_rf[u][rd] = imm;
        end else begin
            return;
        end
        e.rd = rd; e.val = ref_rf[u][rd]; e.sreg = ref_sreg[u];
        if (u == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // Presents ins and returns #1 after its transfer edge; waited is the number
    // of busy negedges seen first, -1 if it never got accepted.
    task automatic xfer(input int u, input logic [15:0] ins, output int waited);
        waited = -1;
        @(negedge clk);
        if (u == 0) begin bus_a.instr = ins; bus_a.instr_valid = 1'b1; end
        else        begin bus_b.instr = ins; bus_b.instr_valid = 1'b1; end
        push_exp(u, ins);
        for (int i = 0; i < 20; i++) begin
            if ((u == 0) ? bus_a.instr_ready : bus_b.instr_ready) begin
                @(posedge clk); #1;
                waited = i;
                break;
            end
            @(negedge clk);
        end
        bus_a.instr_valid = 1'b0;
        bus_b.instr_valid = 1'b0;
    endtask

    task automatic wait_done(input int u, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if ((u == 0) ? done_a : done_b) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic peek(input int u, input logic [1:0] idx, output logic [7:0] v);
        if (u == 0) dbg_sel_a = idx;
        else        dbg_sel_b = idx;
        #1;
        v = (u == 0) ? dbg_data_a : dbg_data_b;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        bus_a.instr = 16'h80AA; bus_a.instr_valid = 1'b1;
        bus_b.instr = 16'h84BB; bus_b.instr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) begin ref_rf[0][r] = '0; ref_rf[1][r] = '0; end
            ref_sreg[0] = '0; ref_sreg[1] = '0;
            @(posedge clk); #1;
            n_cmp++;
            if ({bus_a.instr_ready, bus_b.instr_ready} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_ready_low: got %b%b want 00", bus_a.instr_ready, bus_b.instr_ready);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus_a.instr_valid = 1'b0;
        bus_b.instr_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_a.instr_ready, bus_b.instr_ready, done_a, illegal_a, done_b, illegal_b} !== 6'b110000) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy=%b%b done=%b%b ill=%b%b want rdy=11 done=00 ill=00",
                     bus_a.instr_ready, bus_b.instr_ready, done_a, done_b, illegal_a, illegal_b);
        end
        n_cmp++;
        if ({bus_a.alu_a, bus_a.alu_b, bus_a.alu_opcode, bus_a.alu_sreg_o, sreg_a, sreg_b} !== 44'h0) begin
            n_bad++;
            $display("FAIL reset_alu_outs: got a=%h b=%h op=%h s=%h sreg=%h/%h want all 0",
                     bus_a.alu_a, bus_a.alu_b, bus_a.alu_opcode, bus_a.alu_sreg_o, sreg_a, sreg_b);
        end
        for (int r = 0; r < 4; r++) begin
            peek(0, 2'(r), v);
            n_cmp++;
            if (v !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_rf_a: R%0d got %h want 00", r, v);
            end
        end
    endtask

    task automatic test_ldi();
        exp_t       e;
        logic [7:0] v;
        @(negedge clk);
        bus_a.instr = 16'h8005; bus_a.instr_valid = 1'b1; push_exp(0, 16'h8005);
        @(posedge clk); #1;
        bus_a.instr = 16'h8403; push_exp(0, 16'h8403);
        n_cmp++;
        if (done_a !== 1'b1) begin n_bad++; $display("FAIL ldi_done1: got %b want 1", done_a); end
        @(posedge clk); #1;
        bus_a.instr_valid = 1'b0;
        n_cmp++;
        if (done_a !== 1'b1) begin n_bad++; $display("FAIL ldi_done2: got %b want 1", done_a); end
        @(posedge clk); #1;
        n_cmp++;
        if (done_a !== 1'b0) begin n_bad++; $display("FAIL ldi_done_end: got %b want 0", done_a); end
        while (q_a.size() > 0) begin
            e = q_a.pop_front();
            peek(0, e.rd, v);
            n_cmp++;
            if ({v, sreg_a} !== {e.val, e.sreg}) begin
                n_bad++;
                $display("FAIL ldi_result: R%0d=%h sreg=%h want %h/%h", e.rd, v, sreg_a, e.val, e.sreg);
            end
        end
    endtask

    task automatic test_sub();
        exp_t       e;
        logic [7:0] v;
        int         w, c;
        xfer(0, 16'h3100, w);
        n_cmp++;
        if ({w, bus_a.alu_a, bus_a.alu_b, bus_a.alu_opcode} !== {32'd0, 8'h05, 8'h03, 4'h3}) begin
            n_bad++;
            $display("FAIL sub_issue: wait=%0d a=%h b=%h op=%h want 0/05/03/3",
                     w, bus_a.alu_a, bus_a.alu_b, bus_a.alu_opcode);
        end
        wait_done(0, 10, c);
        n_cmp++;
        if (c !== 3) begin n_bad++; $display("FAIL sub_latency: got %0d edges want 3", c); end
        e = q_a.pop_front();
        peek(0, e.rd, v);
        n_cmp++;
        if ({v, sreg_a} !== {e.val, e.sreg}) begin
            n_bad++;
            $display("FAIL sub_result: R0=%h sreg=%h want %h/%h", v, sreg_a, e.val, e.sreg);
        end
        n_cmp++;
        if (bus_a.alu_a !== 8'h05) begin
            n_bad++;
            $display("FAIL sub_hold: alu_a got %h want 05", bus_a.alu_a);
        end
    endtask

    task automatic test_add_ovf();
        exp_t       e;
        logic [7:0] v;
        int         w, c;
        logic [15:0] ldis [3] = '{16'h80F0, 16'h8420, 16'h8841};
        logic [15:0] ops  [3] = '{16'h2100, 16'h400F, 16'h2A00};
        logic [15:0] iss  [3] = '{16'hF020, 16'h0F40, 16'h4141};
        for (int k = 0; k < 3; k++) begin
            xfer(0, ldis[k], w);
            n_cmp++;
            if (done_a !== 1'b1) begin n_bad++; $display("FAIL ldi_pre_done: #%0d got %b want 1", k, done_a); end
            void'(q_a.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            xfer(0, ops[k], w);
            // operand a / operand b for the two register ops, operand b / SREG for ANDI
            n_cmp++;
            if (k == 1 ? ({bus_a.alu_b, bus_a.alu_sreg_o} !== iss[k])
                       : ({bus_a.alu_a, bus_a.alu_b} !== iss[k])) begin
                n_bad++;
                $display("FAIL alu_issue: op#%0d a=%h b=%h s=%h want %h",
                         k, bus_a.alu_a, bus_a.alu_b, bus_a.alu_sreg_o, iss[k]);
            end
            wait_done(0, 10, c);
            n_cmp++;
            if (c !== 3) begin n_bad++; $display("FAIL alu_latency: op#%0d got %0d want 3", k, c); end
            e = q_a.pop_front();
            peek(0, e.rd, v);
            n_cmp++;
            if ({v, sreg_a} !== {e.val, e.sreg}) begin
                n_bad++;
                $display("FAIL alu_result: op#%0d R%0d=%h sreg=%h want %h/%h", k, e.rd, v, sreg_a, e.val, e.sreg);
            end
            if (k == 0) begin
                n_cmp++;
                if (sreg_a[6] !== 1'b1) begin n_bad++; $display("FAIL add_ovf_v: got %b want 1", sreg_a[6]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] v;
        logic       rdy;
        int         w, c, done_at, acc_at;
        xfer(1, 16'h8407, w);
        xfer(1, 16'h8809, w);
        void'(q_b.pop_front());
        void'(q_b.pop_front());
        xfer(1, 16'h2600, w);
        bus_b.instr = 16'h780A; bus_b.instr_valid = 1'b1;
        push_exp(1, 16'h780A);
        done_at = -1; acc_at = -1;
        for (int i = 1; i <= 12; i++) begin
            rdy = bus_b.instr_ready;
            @(posedge clk); #1;
            if (done_b && done_at < 0) done_at = i;
            if (rdy && bus_b.instr_valid && acc_at < 0) begin
                acc_at = i;
                bus_b.instr_valid = 1'b0;
            end
        end
        bus_b.instr_valid = 1'b0;
        n_cmp++;
        if (done_at !== 5) begin n_bad++; $display("FAIL busy_done_edge: got %0d want 5", done_at); end
        n_cmp++;
        if (acc_at !== 6) begin n_bad++; $display("FAIL busy_accept_edge: got %0d want 6", acc_at); end
        if (acc_at == 6) begin
            // six loop edges after acceptance already passed; done is 5 edges after it
            wait_done(1, 20, c);
            n_cmp++;
            if (c !== -1) begin n_bad++; $display("FAIL busy_second_done: late pulse after %0d edges", c); end
        end
        for (int k = 0; k < 2; k++) begin
            e = q_b.pop_front();
            peek(1, e.rd, v);
            n_cmp++;
            if (v !== e.val) begin n_bad++; $display("FAIL busy_result: R%0d=%h want %h", e.rd, v, e.val); end
        end
        n_cmp++;
        if (sreg_b !== ref_sreg[1]) begin n_bad++; $display("FAIL busy_sreg: got %h want %h", sreg_b, ref_sreg[1]); end
    endtask

    task automatic test_latency3();
        exp_t       e;
        logic [7:0] v;
        int         w, c;
        xfer(1, 16'h6403, w);
        wait_done(1, 12, c);
        n_cmp++;
        if (c !== 5) begin n_bad++; $display("FAIL lat3_done: got %0d edges want 5", c); end
        e = q_b.pop_front();
        peek(1, e.rd, v);
        n_cmp++;
        if ({v, sreg_b} !== {e.val, e.sreg}) begin
            n_bad++;
            $display("FAIL lat3_result: R%0d=%h sreg=%h want %h/%h", e.rd, v, sreg_b, e.val, e.sreg);
        end
    endtask

    task automatic test_illegal_abort();
        logic [7:0] v;
        int         w, nd;
        xfer(0, 16'hA3FF, w);
        n_cmp++;
        if ({illegal_a, done_a} !== 2'b10) begin
            n_bad++;
            $display("FAIL illegal_pulse: ill=%b done=%b want 1/0", illegal_a, done_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_a !== 1'b0) begin n_bad++; $display("FAIL illegal_width: got %b want 0", illegal_a); end
        for (int r = 0; r < 4; r++) begin
            peek(0, 2'(r), v);
            n_cmp++;
            if (v !== ref_rf[0][r]) begin n_bad++; $display("FAIL illegal_rf: R%0d=%h want %h", r, v, ref_rf[0][r]); end
        end
        n_cmp++;
        if (sreg_a !== ref_sreg[0]) begin n_bad++; $display("FAIL illegal_sreg: got %h want %h", sreg_a, ref_sreg[0]); end

        // abort an ADD R3,R1 on the latency-3 instance while it sits in WAIT
        xfer(1, 16'h2D00, w);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done_b) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
        peek(1, 2'd3, v);
        n_cmp++;
        if ({v, sreg_b, bus_b.instr_ready} !== {8'h00, 8'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_state: R3=%h sreg=%h rdy=%b want 00/00/1", v, sreg_b, bus_b.instr_ready);
        end
    endtask

    initial begin
        bus_a.instr = '0; bus_a.instr_valid = 1'b0;
        bus_b.instr = '0; bus_b.instr_valid = 1'b0;
        dbg_sel_a = '0; dbg_sel_b = '0;
        test_reset();
        test_ldi();
        test_sub();
        test_add_ovf();
        test_back_to_back();
        test_latency3();
        test_illegal_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
